pet_stats_engine: RTL and testbench
===================================

# pet_stats_engine

Parametrised need-statistics engine for the tamagotchi core. It holds N_STATS saturating need counters. Each counter rises over time via a random-channel decay tick and falls on edge-detected care buttons. The engine adds a sleep mode, per-channel alarm flags and a death state. It sits between the button/LFSR front end and the display/behaviour logic, and succeeds the fixed six-stat tracker.

## Interface
- N_STATS, 6, number of stat channels (2..16)
- STAT_W, 4, bits per stat; max value MAXV = 2^STAT_W-1
- TICK_DIV, 10000, clock cycles per decay period (>=2)
- CARE_STEP, 1, amount subtracted per care event (1..MAXV)
- ALARM_LVL, 12, alarm threshold (<= MAXV)
- GRACE_TICKS, 8, consecutive applied ticks with any stat at MAXV before death (>=1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clock clk
- care  in  N_STATS  care buttons, level, one bit per channel, synchronous to clk
- sleep_req  in  1  level; 1 requests sleep
- random  in  8  random value from LFSR, sampled on tick cycles
- stats  out  N_STATS*STAT_W  packed stat registers, channel i at [i*STAT_W +: STAT_W]
- alarm  out  N_STATS  alarm[i] = (stat i >= ALARM_LVL), combinational from stat registers
- state  out  2  0=AWAKE, 1=SLEEP, 2=DEAD
- tick  out  1  registered one-cycle pulse, high the cycle after a decay tick is applied

## Operation
- Reset values: all stats 0, alarm 0, state AWAKE, tick 0, prescaler 0, sleep phase 0, grace counter 0, care_prev all ones. A button held through reset release does not fire.
- Prescaler counts 0..TICK_DIV-1 and wraps. A raw tick occurs in the cycle where the count equals TICK_DIV-1.
- Applied tick:
  - AWAKE: every raw tick is applied.
  - SLEEP: every second raw tick is applied. The phase bit toggles on each raw tick and is cleared on sleep entry.
  - DEAD: no tick is applied and the prescaler holds.
- Decay: on an applied tick, channel k = random mod N_STATS gets +1.
- Care event: rising edge on care[i] (care[i]=1 and care_prev[i]=0), in AWAKE only. Events in SLEEP and DEAD are ignored. care_prev updates every cycle in all states.
- Per-channel update, computed in STAT_W+2-bit signed arithmetic: next = stat + inc - dec, where inc is 1 if decayed and dec is CARE_STEP if cared. The result is clamped to [0, MAXV]. A simultaneous decay and care on the same channel therefore nets out before clamping; for example, 15 +1 -1 stays 15.
- Independent channels update in parallel in the same cycle. Any number of care edges may occur in one cycle.
- FSM transitions:
  - AWAKE -> SLEEP when sleep_req=1.
  - SLEEP -> AWAKE when sleep_req=0.
  - AWAKE/SLEEP -> DEAD when the grace counter reaches GRACE_TICKS.
  - DEAD is exited only by reset.
  - Death takes priority over a sleep transition in the same cycle.
- Grace counter:
  - Evaluated only on applied ticks, using stat values before that tick's update.
  - Increments if any stat equals MAXV; otherwise clears to 0.
  - Saturates at GRACE_TICKS.
- DEAD: stats are frozen, alarm keeps reflecting the frozen stats, and tick stays 0.

## Timing
- Stats, FSM, grace counter and tick all register on the same clock edge.
- A stat changes on the edge that ends the raw-tick cycle (count = TICK_DIV-1). tick is high during the following cycle, coincident with the new stat value.
- Care latency: a care edge at cycle n produces the new stat at cycle n+1. alarm follows in the same cycle as the stat.
- Sleep entry/exit takes effect on the edge after sleep_req changes. A raw tick in that same cycle uses the old state.
- Entering DEAD occurs on the edge of the applied tick that makes grace = GRACE_TICKS. That tick's decay is still applied.
- Asynchronous reset mid-period returns every register to its reset value immediately, regardless of state.

## Test plan
Bench parameters: TICK_DIV=4, N_STATS=6, STAT_W=4, CARE_STEP=1, ALARM_LVL=12, GRACE_TICKS=8.
- Decay selection: release reset, hold random=7 -> tick pulse at cycle 4; stat1=1, all other stats 0; stat1=2 after cycle 8.
- Saturation and alarm: hold random=0 for 16 ticks -> stat0 reaches 15 and stays 15; alarm[0] rises on the tick that makes stat0=12; alarm[5:1]=0.
- Care edges: stat0=5, hold care[0]=1 for 10 cycles -> stat0=4 (one event only); care[0] held through reset release -> no decrement; stat3=0 with a care edge -> stays 0.
- Simultaneous events: stat2=15, care edge on channel 2 in a raw-tick cycle with random=2 -> stat2=15; with stat2=0 -> stat2=0.
- Sleep: sleep_req=1 -> state=1, ticks every 8 cycles, care edges ignored; sleep_req=0 -> state=0 next cycle, care works again.
- Death: stat0 at 15, random=1 -> state=2 after 8 applied ticks; then stats frozen, tick=0 and care ignored for 50 cycles; reset -> stats 0, state=0.

Source files
------------

// File: rtl/pet_stats_engine.sv
// pet_stats_engine: N_STATS saturating need counters for the tamagotchi core.
// Each counter rises on a randomly selected decay tick and falls on edge-detected
// care buttons. Adds a sleep mode (half-rate ticks, care ignored), per-channel
// alarm flags and a terminal DEAD state entered after GRACE_TICKS consecutive
// applied ticks with any stat at its maximum.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high
//   care       care buttons, level, one bit per channel
//   sleep_req  level, 1 requests sleep
//   random     LFSR value, selects the decaying channel on applied ticks
//   stats      packed stat registers, channel i at [i*STAT_W +: STAT_W]
//   alarm      combinational, alarm[i] = stat i >= ALARM_LVL
//   state      0 = AWAKE, 1 = SLEEP, 2 = DEAD
//   tick       registered pulse, high the cycle after a decay tick is applied
module pet_stats_engine #(
    parameter int unsigned N_STATS     = 6,
    parameter int unsigned STAT_W      = 4,
    parameter int unsigned TICK_DIV    = 10000,
    parameter int unsigned CARE_STEP   = 1,
    parameter int unsigned ALARM_LVL   = 12,
    parameter int unsigned GRACE_TICKS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_STATS-1:0]          care,
    input  logic                        sleep_req,
    input  logic [7:0]                  random,
    output logic [N_STATS*STAT_W-1:0]   stats,
    output logic [N_STATS-1:0]          alarm,
    output logic [1:0]                  state,
    output logic                        tick
);

    localparam int unsigned MAXV  = (1 << STAT_W) - 1;
    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam int unsigned GR_W  = $clog2(GRACE_TICKS + 1);
    localparam int unsigned SW    = STAT_W + 2;

    localparam logic signed [SW-1:0] ONE_S  = SW'(1);
    localparam logic signed [SW-1:0] STEP_S = SW'(CARE_STEP);
    localparam logic signed [SW-1:0] MAX_S  = SW'(MAXV);

    typedef enum logic [1:0] {
        ST_AWAKE = 2'd0,
        ST_SLEEP = 2'd1,
        ST_DEAD  = 2'd2
    } st_e;

    st_e                st_q, st_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               phase_q, phase_d;
    logic [GR_W-1:0]    grace_q, grace_d;
    logic [N_STATS-1:0] care_prev_q;
    logic [STAT_W-1:0]  stat_q [N_STATS];
    logic [STAT_W-1:0]  stat_d [N_STATS];

    logic               raw_tick;
    logic               applied;
    logic [7:0]         dec_ch;
    logic [N_STATS-1:0] care_ev;
    logic               any_max;

    // Tick qualification: prescaler wrap, halved in SLEEP, none in DEAD
    assign raw_tick = (st_q != ST_DEAD) && (cnt_q == CNT_W'(TICK_DIV - 1));
    assign applied  = raw_tick && ((st_q == ST_AWAKE) || ((st_q == ST_SLEEP) && phase_q));
    assign dec_ch   = random % 8'(N_STATS);
    assign care_ev  = (st_q == ST_AWAKE) ? (care & ~care_prev_q) : '0;
    assign state    = st_q;

    // Any channel pinned at maximum, sampled before this cycle's update
    always_comb begin
        any_max = 1'b0;
        for (int k = 0; k < N_STATS; k++) begin
            if (stat_q[k] == STAT_W'(MAXV)) any_max = 1'b1;
        end
    end

    // Per-channel update: net the decay and care first, then clamp
    for (genvar g = 0; g < N_STATS; g++) begin : g_ch
        logic signed [SW-1:0] sum;
        logic [STAT_W-1:0]    nxt;

        always_comb begin
            sum = $signed(SW'(stat_q[g]));
            if (applied && (dec_ch == 8'(g))) sum = sum + ONE_S;
            if (care_ev[g]) sum = sum - STEP_S;
            if (sum[SW-1]) nxt = '0;
            else if (sum > MAX_S) nxt = STAT_W'(MAXV);
            else nxt = sum[STAT_W-1:0];
        end

        assign stat_d[g]                   = nxt;
        assign stats[g*STAT_W +: STAT_W]   = stat_q[g];
        assign alarm[g]                    = (stat_q[g] >= STAT_W'(ALARM_LVL));
    end

    // Next-state: prescaler, sleep phase, grace counter and FSM
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q ^ raw_tick;
        grace_d = grace_q;
        st_d    = st_q;

        if (st_q != ST_DEAD) cnt_d = raw_tick ? '0 : cnt_q + CNT_W'(1);

        if (applied) begin
            if (!any_max) grace_d = '0;
            else if (grace_q != GR_W'(GRACE_TICKS)) grace_d = grace_q + GR_W'(1);
        end

        case (st_q)
            ST_AWAKE: begin
                if (grace_d == GR_W'(GRACE_TICKS)) begin
                    st_d = ST_DEAD;
                end else if (sleep_req) begin
                    st_d    = ST_SLEEP;
                    phase_d = 1'b0;
                end
            end
            ST_SLEEP: begin
                if (grace_d == GR_W'(GRACE_TICKS)) st_d = ST_DEAD;
                else if (!sleep_req) st_d = ST_AWAKE;
            end
            default: st_d = st_q;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q        <= ST_AWAKE;
            cnt_q       <= '0;
            phase_q     <= 1'b0;
            grace_q     <= '0;
            care_prev_q <= '1;
            tick        <= 1'b0;
            for (int k = 0; k < N_STATS; k++) stat_q[k] <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            grace_q     <= grace_d;
            care_prev_q <= care;
            tick        <= applied;
            stat_q      <= stat_d;
        end
    end

endmodule

// File: tb/tb_pet_stats_engine.sv
// Testbench for pet_stats_engine: a cycle model feeds a per-cycle scoreboard,
// a vector table walks the main scenarios with hand-derived checkpoints, and
// hand-written sequences cover async reset and the first-tick timing.
module tb_pet_stats_engine;

    localparam int N    = 6;
    localparam int W    = 4;
    localparam int TD   = 4;
    localparam int CS   = 1;
    localparam int AL   = 12;
    localparam int GT   = 8;
    localparam int MAXV = 15;
    localparam int NV   = 19;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     care;
    logic             sleep_req;
    logic [7:0]       random;
    logic [N*W-1:0]   stats;
    logic [N-1:0]     alarm;
    logic [1:0]       state;
    logic             tick;

    always #5 clk = ~clk;

    pet_stats_engine #(
        .N_STATS(N), .STAT_W(W), .TICK_DIV(TD), .CARE_STEP(CS),
        .ALARM_LVL(AL), .GRACE_TICKS(GT)
    ) dut (
        .clk(clk), .reset(reset), .care(care), .sleep_req(sleep_req),
        .random(random), .stats(stats), .alarm(alarm), .state(state), .tick(tick)
    );

    typedef struct packed {
        logic [N*W-1:0] stats;
        logic [N-1:0]   alarm;
        logic [1:0]     state;
        logic           tick;
    } exp_t;

    typedef struct {
        logic [N-1:0] care;
        logic         sr;
        logic [7:0]   rnd;
        int           cycles;
        int           ch;
        int           val;
        int           st;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[NV];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int         m_stat[N];
    int         m_cnt, m_phase, m_grace, m_state, m_tick;
    logic [N-1:0] m_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_stat[k] = 0;
        m_cnt = 0; m_phase = 0; m_grace = 0; m_state = 0; m_tick = 0;
        m_prev = '1;
    endtask

    task automatic model_step(input logic [N-1:0] c, input logic sr, input logic [7:0] r);
        bit raw, app, anymax;
        int v, ng;
        raw = (m_state != 2) && (m_cnt == TD - 1);
        app = raw && ((m_state == 0) || ((m_state == 1) && (m_phase == 1)));
        anymax = 0;
        for (int k = 0; k < N; k++) if (m_stat[k] == MAXV) anymax = 1;
        for (int k = 0; k < N; k++) begin
            v = m_stat[k];
            if (app && ((int'(r) % N) == k)) v = v + 1;
            if ((m_state == 0) && c[k] && !m_prev[k]) v = v - CS;
            if (v < 0) v = 0;
            if (v > MAXV) v = MAXV;
            m_stat[k] = v;
        end
        ng = m_grace;
        if (app) ng = anymax ? ((m_grace < GT) ? m_grace + 1 : GT) : 0;
        m_grace = ng;
        if (raw) m_phase = 1 - m_phase;
        if (m_state != 2) m_cnt = raw ? 0 : m_cnt + 1;
        if ((m_state != 2) && (ng == GT)) m_state = 2;
        else if ((m_state == 0) && sr) begin m_state = 1; m_phase = 0; end
        else if ((m_state == 1) && !sr) m_state = 0;
        m_tick = app ? 1 : 0;
        m_prev = c;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.stats[k*W +: W] = W'(m_stat[k]);
            e.alarm[k]        = (m_stat[k] >= AL);
        end
        e.state = 2'(m_state);
        e.tick  = (m_tick != 0);
        return e;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sb_underflow: got empty queue expected one entry");
            return;
        end
        e = sb_q.pop_front();
        check("cyc_stats", 32'(stats), 32'(e.stats));
        check("cyc_alarm", 32'(alarm), 32'(e.alarm));
        check("cyc_state", 32'(state), 32'(e.state));
        check("cyc_tick",  32'(tick),  32'(e.tick));
    endtask

    // Drive one cycle of stimulus, predict, and compare after the edge
    task automatic run_cycle(input logic [N-1:0] c, input logic sr, input logic [7:0] r);
        care = c; sleep_req = sr; random = r;
        model_step(c, sr, r);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // care, sleep_req, random, cycles, checked channel, expected value, expected state
        tbl[0]  = '{6'b000000, 1'b0, 8'd7,  5, 1,  1, 0};
        tbl[1]  = '{6'b000000, 1'b0, 8'd7,  4, 1,  2, 0};
        tbl[2]  = '{6'b000000, 1'b0, 8'd0, 64, 0, 15, 0};
        tbl[3]  = '{6'b000001, 1'b0, 8'd3, 10, 0, 14, 0};
        tbl[4]  = '{6'b000000, 1'b0, 8'd3,  1, 3,  3, 0};
        tbl[5]  = '{6'b010000, 1'b0, 8'd3,  2, 4,  0, 0};
        tbl[6]  = '{6'b000000, 1'b0, 8'd3,  1, 4,  0, 0};
        tbl[7]  = '{6'b100000, 1'b0, 8'd5,  2, 5,  0, 0};
        tbl[8]  = '{6'b000000, 1'b0, 8'd0,  4, 0, 15, 0};
        tbl[9]  = '{6'b000000, 1'b0, 8'd0,  2, 0, 15, 0};
        tbl[10] = '{6'b000001, 1'b0, 8'd0,  1, 0, 15, 0};
        tbl[11] = '{6'b000000, 1'b1, 8'd1,  1, 0, 15, 1};
        tbl[12] = '{6'b000000, 1'b1, 8'd1,  8, 1,  3, 1};
        tbl[13] = '{6'b000001, 1'b1, 8'd1,  4, 0, 15, 1};
        tbl[14] = '{6'b000000, 1'b0, 8'd1,  1, 1,  3, 0};
        tbl[15] = '{6'b000001, 1'b0, 8'd1,  2, 0, 14, 0};
        tbl[16] = '{6'b000000, 1'b0, 8'd0,  4, 0, 15, 0};
        tbl[17] = '{6'b000000, 1'b0, 8'd1, 32, 1, 12, 2};
        tbl[18] = '{6'b000011, 1'b0, 8'd1, 50, 1, 12, 2};

        reset = 1'b1; care = '1; sleep_req = 1'b0; random = 8'd0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_stats", 32'(stats), 32'd0);
        check("rst_alarm", 32'(alarm), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_tick",  32'(tick),  32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            for (int j = 0; j < tbl[i].cycles; j++) run_cycle(tbl[i].care, tbl[i].sr, tbl[i].rnd);
            check($sformatf("vec%0d_stat%0d", i, tbl[i].ch), 32'(stats[tbl[i].ch*W +: W]), 32'(tbl[i].val));
            check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
        end
        check("dead_alarm", 32'(alarm), 32'b000011);
        check("dead_tick",  32'(tick),  32'd0);

        // Async reset in the middle of a cycle while DEAD, care held through release
        @(negedge clk);
        reset = 1'b1;
        care  = 6'b000001;
        #1;
        check("arst_stats", 32'(stats), 32'd0);
        check("arst_alarm", 32'(alarm), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        check("arst_tick",  32'(tick),  32'd0);
        sb_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int j = 0; j < 4; j++) run_cycle(6'b000001, 1'b0, 8'd0);
        check("first_tick", 32'(tick), 32'd1);
        check("first_stat0", 32'(stats[W-1:0]), 32'd1);
        for (int j = 0; j < 4; j++) run_cycle(6'b000001, 1'b0, 8'd0);
        check("second_tick", 32'(tick), 32'd1);
        check("held_care_stat0", 32'(stats[W-1:0]), 32'd2);
        run_cycle(6'b000000, 1'b0, 8'd0);
        run_cycle(6'b000001, 1'b0, 8'd0);
        check("fresh_edge_stat0", 32'(stats[W-1:0]), 32'd1);
        check("fresh_edge_tick", 32'(tick), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
